// File: rtl/blink_sequencer_pkg.sv
// ============================================================================
// blink_pkg
// Shared types and helpers for the blink_sequencer LED pattern controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int DUR_W_DEF = 8;
  localparam int LED_BIT   = DUR_W_DEF;

  // An entry is {led, duration}; the LED level sits just above the duration field.
  function automatic int led_bit(input int dur_w);
    return dur_w;
  endfunction

  function automatic logic [31:0] default_inc(input longint clk_hz, input longint tick_hz);
    logic [63:0] num;
    num = 64'(tick_hz) << 32;
    return 32'(num / 64'(clk_hz));
  endfunction

endpackage

`default_nettype wire

// File: rtl/blink_sequencer_if.sv
// ============================================================================
// blink_sequencer_if
// Host write port, pattern control and LED/status outputs of blink_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface blink_sequencer_if #(
  parameter int NSTEPS = 8,
  parameter int DUR_W  = 8
);
  localparam int AW = $clog2(NSTEPS);

  logic              i_wr;
  logic [AW-1:0]     i_waddr;
  logic [DUR_W:0]    i_wdata;
  logic              i_inc_wr;
  logic [31:0]       i_inc;
  logic              i_start;
  logic              i_stop;
  logic              i_repeat;
  logic              o_led;
  logic              o_busy;
  logic              o_done;
  logic              o_tick;

  modport master (
    output i_wr, i_waddr, i_wdata, i_inc_wr, i_inc, i_start, i_stop, i_repeat,
    input  o_led, o_busy, o_done, o_tick
  );

  modport slave (
    input  i_wr, i_waddr, i_wdata, i_inc_wr, i_inc, i_start, i_stop, i_repeat,
    output o_led, o_busy, o_done, o_tick
  );

endinterface

`default_nettype wire

// File: rtl/blink_sequencer_tick_gen.sv
// ============================================================================
// tick_gen
// 32-bit phase accumulator; a carry-out becomes a one-cycle tick next cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter logic [31:0] INCREMENT = 32'd4294
) (
  input  wire logic        i_clk,
  input  wire logic        i_reset,
  input  wire logic        i_clr,
  input  wire logic        i_en,
  input  wire logic        i_inc_wr,
  input  wire logic [31:0] i_inc,
  output logic             o_tick
);

  logic [31:0] acc_q, acc_d;
  logic [31:0] inc_q, inc_d;
  logic        tick_q, tick_d;
  logic [32:0] sum;

  // The sum always uses the current increment, so a load lands after any in-flight tick.
  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, inc_q};
    acc_d  = acc_q;
    tick_d = 1'b0;
    inc_d  = i_inc_wr ? i_inc : inc_q;
    if (i_clr) begin
      acc_d = '0;
    end else if (i_en) begin
      acc_d  = sum[31:0];
      tick_d = sum[32];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_q  <= '0;
      inc_q  <= INCREMENT;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      inc_q  <= inc_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/blink_sequencer.sv
// ============================================================================
// blink_sequencer
// Steps the LED through a stored list of {led, duration} entries, timed by tick_gen.
// Revision: 1.0
// ============================================================================
`default_nettype none

module blink_sequencer
  import blink_pkg::*;
#(
  parameter int          CLOCK_RATE_HZ = 100_000_000,
  parameter int          TICK_HZ       = 100,
  parameter logic [31:0] INCREMENT     = default_inc(CLOCK_RATE_HZ, TICK_HZ),
  parameter int          NSTEPS        = 8,
  parameter int          DUR_W         = DUR_W_DEF
) (
  input wire logic          i_clk,
  input wire logic          i_reset,
  blink_sequencer_if.slave  bus
);

  localparam int              IDX_W   = $clog2(NSTEPS);
  localparam int              LED_POS = led_bit(DUR_W);
  localparam logic [IDX_W:0]  IDX_ONE = 1;
  localparam logic [DUR_W-1:0] DUR_ONE = 1;

  state_e             state_q, state_d;
  logic [IDX_W:0]     idx_q, idx_d;
  logic [DUR_W-1:0]   remain_q, remain_d;
  logic               led_q, led_d;
  logic               done_q, done_d;
  logic [DUR_W:0]     ram_q [NSTEPS];
  logic [DUR_W:0]     ram_d [NSTEPS];
  logic [DUR_W:0]     entry;
  logic               term;
  logic               busy;
  logic               tick;

  assign busy = (state_q != ST_IDLE);

  tick_gen #(
    .INCREMENT (INCREMENT)
  ) u_tick_gen (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clr    (!busy),
    .i_en     (busy),
    .i_inc_wr (bus.i_inc_wr),
    .i_inc    (bus.i_inc),
    .o_tick   (tick)
  );

  always_comb begin
    for (int k = 0; k < NSTEPS; k++) begin
      ram_d[k] = ram_q[k];
      if (bus.i_wr && !busy && (bus.i_waddr == IDX_W'(k))) begin
        ram_d[k] = bus.i_wdata;
      end
    end
  end

  // The extra index bit flags a walk past the last entry, which ends the pattern.
  always_comb begin
    entry    = ram_q[idx_q[IDX_W-1:0]];
    term     = idx_q[IDX_W] || (entry[DUR_W-1:0] == '0);
    state_d  = state_q;
    idx_d    = idx_q;
    remain_d = remain_q;
    led_d    = led_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        led_d = 1'b0;
        if (bus.i_start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        if (term) begin
          if (bus.i_repeat && (idx_q != '0)) begin
            idx_d = '0;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          remain_d = entry[DUR_W-1:0];
          led_d    = entry[LED_POS];
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick) begin
          remain_d = remain_q - DUR_ONE;
          if (remain_q == DUR_ONE) begin
            idx_d   = idx_q + IDX_ONE;
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.i_stop && busy) begin
      state_d = ST_IDLE;
      led_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      remain_q <= '0;
      led_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      remain_q <= remain_d;
      led_q    <= led_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge i_clk) begin
    ram_q <= ram_d;
  end

  assign bus.o_led  = led_q;
  assign bus.o_busy = busy;
  assign bus.o_done = done_q;
  assign bus.o_tick = tick;

endmodule

`default_nettype wire

// File: tb/tb_blink_sequencer.sv
// ============================================================================
// tb_blink_sequencer
// Directed scoreboard bench for blink_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_blink_sequencer;
  import blink_pkg::*;

  localparam int NSTEPS = 8;
  localparam int DUR_W  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  blink_sequencer_if #(.NSTEPS(NSTEPS), .DUR_W(DUR_W)) bus ();

  blink_sequencer #(
    .CLOCK_RATE_HZ (100_000_000),
    .TICK_HZ       (100),
    .NSTEPS        (NSTEPS),
    .DUR_W         (DUR_W)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic led;
    logic busy;
    logic done;
    logic tick;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic led, input logic busy, input logic done, input logic tick);
    exp_t e;
    e.led  = led;
    e.busy = busy;
    e.done = done;
    e.tick = tick;
    sb.push_back(e);
  endtask

  // Pattern {1,3},{0,2},term at one tick per 4 cycles; index i = cycles after the start edge.
  task automatic push_oneshot(input int n);
    for (int i = 0; i < n; i++) begin
      push((i >= 1) && (i <= 13), i <= 21, i == 22, (i > 0) && (i % 4 == 0) && (i <= 20));
    end
  endtask

  task automatic drain(input string tag, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      if (sb.size() == 0) begin
        chk($sformatf("%s.sb_empty", tag), 1'b1, 1'b0);
        break;
      end
      e = sb.pop_front();
      chk($sformatf("%s[%0d].led", tag, k), bus.o_led, e.led);
      chk($sformatf("%s[%0d].busy", tag, k), bus.o_busy, e.busy);
      chk($sformatf("%s[%0d].done", tag, k), bus.o_done, e.done);
      chk($sformatf("%s[%0d].tick", tag, k), bus.o_tick, e.tick);
      @(negedge clk);
    end
  endtask

  task automatic write_entry(input int a, input logic [DUR_W:0] d);
    bus.i_wr    = 1'b1;
    bus.i_waddr = 3'(a);
    bus.i_wdata = d;
    @(negedge clk);
    bus.i_wr    = 1'b0;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  initial begin
    bus.i_wr     = 1'b0;
    bus.i_waddr  = '0;
    bus.i_wdata  = '0;
    bus.i_inc_wr = 1'b0;
    bus.i_inc    = '0;
    bus.i_start  = 1'b0;
    bus.i_stop   = 1'b0;
    bus.i_repeat = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.led", bus.o_led, 1'b0);
    chk("reset.busy", bus.o_busy, 1'b0);
    chk("reset.done", bus.o_done, 1'b0);
    chk("reset.tick", bus.o_tick, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    bus.i_inc_wr = 1'b1;
    bus.i_inc    = 32'h4000_0000;
    @(negedge clk);
    bus.i_inc_wr = 1'b0;
    write_entry(0, 9'h103);
    write_entry(1, 9'h002);
    write_entry(2, 9'h100);

    // One-shot run
    push_oneshot(25);
    pulse_start();
    drain("oneshot", 25);

    // Repeating run: steady-state period of 20 cycles once the tick phase settles
    bus.i_repeat = 1'b1;
    for (int i = 0; i < 45; i++) begin
      push(((i >= 1) && (i <= 13)) || ((i >= 23) && ((i - 23) % 20 <= 10)), 1'b1, 1'b0,
           (i > 0) && (i % 4 == 0));
    end
    pulse_start();
    drain("repeat", 45);
    bus.i_stop  = 1'b1;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_stop  = 1'b0;
    bus.i_start = 1'b0;
    chk("stop.led", bus.o_led, 1'b0);
    chk("stop.busy", bus.o_busy, 1'b0);
    chk("stop.done", bus.o_done, 1'b0);
    @(negedge clk);
    chk("stop.done2", bus.o_done, 1'b0);
    chk("stop.busy2", bus.o_busy, 1'b0);
    bus.i_repeat = 1'b0;
    @(negedge clk);

    // Writes and restarts while busy must have no effect
    push_oneshot(25);
    pulse_start();
    drain("busy", 5);
    bus.i_wr     = 1'b1;
    bus.i_waddr  = 3'd0;
    bus.i_wdata  = 9'h001;
    bus.i_start  = 1'b1;
    drain("busy", 1);
    bus.i_wr     = 1'b0;
    bus.i_start  = 1'b0;
    drain("busy", 19);
    push_oneshot(25);
    pulse_start();
    drain("rerun", 25);

    // Reset in RUN just before a tick would appear
    push_oneshot(7);
    pulse_start();
    drain("prerst", 7);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_run.led", bus.o_led, 1'b0);
    chk("rst_run.busy", bus.o_busy, 1'b0);
    chk("rst_run.done", bus.o_done, 1'b0);
    chk("rst_run.tick", bus.o_tick, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Empty pattern with repeat: must end instead of looping
    write_entry(0, 9'h100);
    bus.i_repeat = 1'b1;
    push(1'b0, 1'b1, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b0);
    pulse_start();
    drain("empty", 4);
    bus.i_repeat = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
